vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Display-side reader for the graphics memory. Generates 640x480@60 VGA timing from memclk using a pixel-enable divider.
- Issues linear 320x240 framebuffer read addresses on vgactl_addr, with 2x horizontal and 2x vertical pixel doubling.
- Captures the returned 8-bit RGB332 colour and drives 4-bit-per-channel VGA outputs plus the sync signals.
- Sits between the gmem read port and the board VGA pins.

Parameters:
- CLK_DIV, 4, memclk cycles per pixel; must satisfy CLK_DIV > READ_LAT.
- READ_LAT, 2, memclk cycles from vgactl_addr to valid vgactl_dat (gram register plus output register).
- H_VIS, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_VIS, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- FB_W, 320, framebuffer width in pixels.

Ports:
- memclk  in  1  system/memory clock
- rst  in  1  synchronous, active-low reset
- vgactl_addr  out  17  framebuffer pixel index to gmem
- vgactl_dat  in  8  RGB332 pixel returned by gmem, READ_LAT cycles after the address
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vblank_irq  out  1  frame interrupt pulse (see Optional Feature)

Behaviour:
- Reset: rst sampled on memclk; while low, all outputs and counters clear.
  - div_cnt, hcnt, vcnt, row_base = 0; vgactl_addr = 0.
  - vga_r/g/b = 0; vga_hs = 1; vga_vs = 1; vblank_irq = 0.
  - Reset mid-frame restarts timing at hcnt=0, vcnt=0 on the first cycle after release.
- Pixel tick: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick is high when div_cnt == CLK_DIV-1.
- Counters (advance on pix_tick only):
  - hcnt counts 0..799 (H total) and wraps to 0.
  - On hcnt wrap, vcnt counts 0..524 (V total) and wraps to 0.
- Visible region: active = (hcnt < H_VIS) && (vcnt < V_VIS).
- Address generation, no multiplier:
  - row_base is 17 bits. It resets to 0 when vcnt wraps to 0.
  - On each hcnt wrap where the line just finished is odd and visible (vcnt < V_VIS and vcnt[0] == 1), row_base += FB_W.
  - vgactl_addr = row_base + hcnt[9:1] while active, registered on pix_tick.
  - Outside the active region, vgactl_addr holds its last value.
  - Last visible pixel (hcnt=639, vcnt=479) yields address 76799. The address never exceeds 76799.
- Data capture: vgactl_dat is captured exactly READ_LAT memclk cycles after the pix_tick that updated vgactl_addr, into pix_q.
- Output stage: pipeline of one pixel period.
  - On pix_tick, the colour, active, hs and vs of the previous pixel position are registered to the outputs.
  - Sync and colour therefore stay aligned.
- Sync generation:
  - hs_raw = 0 when H_VIS+H_FP <= hcnt < H_VIS+H_FP+H_SYNC (656..751).
  - vs_raw = 0 when V_VIS+V_FP <= vcnt < V_VIS+V_FP+V_SYNC (490..491).
- Colour expansion from pix_q = {r[2:0], g[2:0], b[1:0]}:
  - vga_r = {r, r[2]}
  - vga_g = {g, g[2]}
  - vga_b = {b, b}
- Blanking: when the delayed active is 0, vga_r/g/b = 0.
- Outputs change only in the memclk cycle after pix_tick.

Optional Feature:
- Macro: VGA_VBLANK_IRQ_EN.
- Defined: vblank_irq pulses high for exactly 1 memclk cycle. The pulse occurs on the cycle after the pix_tick at which (hcnt, vcnt) becomes (0, V_VIS), i.e. once per frame at vblank start.
- Undefined: vblank_irq is tied to 0 and no irq logic is synthesised. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 5 cycles with random vgactl_dat -> all colour outputs 0, vga_hs=vga_vs=1, vgactl_addr=0. After release, first pix_tick occurs at cycle 4 (CLK_DIV=4).
- Line timing: run 2 lines -> vga_hs low for exactly 96*4=384 memclk cycles per line. hsync falling edges are 800*4=3200 cycles apart. vsync low for 2*3200 cycles per 525-line frame.
- Address pattern:
  - Line 0, hcnt 0,1,2,3 -> addr 0,0,1,1.
  - Line 1 reuses base 0; line 2, hcnt 0 -> addr 320.
  - Line 479, hcnt 639 -> addr 76799.
  - Next frame line 0 -> addr 0.
- Colour mapping: gmem model with READ_LAT=2 returning 0xE3 -> vga_r=F, vga_g=0, vga_b=F, one pixel period later. 0x1C -> r=0, g=F, b=0.
- Blanking: a model returning 0xFF everywhere -> vga_r/g/b=0 for all positions with hcnt>=640 or vcnt>=480.
- Reset mid-frame: assert rst at vcnt=200 for 1 cycle -> counters restart, and the next active pixel requests addr 0.
- IRQ (with VGA_VBLANK_IRQ_EN defined): exactly one 1-cycle vblank_irq pulse per frame at vcnt=480, hcnt=0. Without the macro, vblank_irq stays 0.

Source files
------------

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: reads a 320x240 RGB332 framebuffer with 2x2 pixel doubling.
// Optional vblank interrupt pulse is built only when VGA_VBLANK_IRQ_EN is defined.
module vga_scanout #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned FB_W     = 320
) (
  input  logic        memclk,
  input  logic        rst,
  output logic [16:0] vgactl_addr,
  input  logic [7:0]  vgactl_dat,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vblank_irq
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_hcnt;
  logic [9:0]       r_vcnt;
  logic [16:0]      r_row_base;
  logic [16:0]      r_addr;
  logic [7:0]       r_pix_q;
  logic             r_act_d;
  logic             r_hs_d;
  logic             r_vs_d;
  logic [3:0]       r_vga_r;
  logic [3:0]       r_vga_g;
  logic [3:0]       r_vga_b;
  logic             r_vga_hs;
  logic             r_vga_vs;

  logic        w_pix_tick;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_active;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic [7:0]  w_pix;
  logic [16:0] w_addr;

  assign w_pix_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_h_wrap   = (r_hcnt == 10'(H_TOT - 1));
  assign w_v_wrap   = (r_vcnt == 10'(V_TOT - 1));
  assign w_active   = (r_hcnt < 10'(H_VIS)) && (r_vcnt < 10'(V_VIS));
  assign w_hs_raw   = !((r_hcnt >= 10'(H_VIS + H_FP)) && (r_hcnt < 10'(H_VIS + H_FP + H_SYNC)));
  assign w_vs_raw   = !((r_vcnt >= 10'(V_VIS + V_FP)) && (r_vcnt < 10'(V_VIS + V_FP + V_SYNC)));
  assign w_addr     = r_row_base + {8'd0, r_hcnt[9:1]};
  // When data lands on the tick edge itself, bypass pix_q so the output sees it in time.
  assign w_pix      = (READ_LAT == CLK_DIV - 1) ? vgactl_dat : r_pix_q;

  always_ff @(posedge memclk) begin
    if (!rst) begin
      r_div_cnt  <= '0;
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_pix_q    <= '0;
      r_act_d    <= 1'b0;
      r_hs_d     <= 1'b1;
      r_vs_d     <= 1'b1;
      r_vga_r    <= '0;
      r_vga_g    <= '0;
      r_vga_b    <= '0;
      r_vga_hs   <= 1'b1;
      r_vga_vs   <= 1'b1;
    end else begin
      r_div_cnt <= w_pix_tick ? '0 : r_div_cnt + 1'b1;
      if (r_div_cnt == DIV_W'(READ_LAT)) begin
        r_pix_q <= vgactl_dat;
      end
      if (w_pix_tick) begin
        r_hcnt <= w_h_wrap ? '0 : r_hcnt + 10'd1;
        if (w_h_wrap) begin
          r_vcnt <= w_v_wrap ? '0 : r_vcnt + 10'd1;
          // Advance one framebuffer row after every second visible line.
          if (w_v_wrap) begin
            r_row_base <= '0;
          end else if ((r_vcnt < 10'(V_VIS)) && r_vcnt[0]) begin
            r_row_base <= r_row_base + 17'(FB_W);
          end
        end
        if (w_active) begin
          r_addr <= w_addr;
        end
        r_act_d  <= w_active;
        r_hs_d   <= w_hs_raw;
        r_vs_d   <= w_vs_raw;
        r_vga_hs <= r_hs_d;
        r_vga_vs <= r_vs_d;
        r_vga_r  <= r_act_d ? {w_pix[7:5], w_pix[7]} : 4'd0;
        r_vga_g  <= r_act_d ? {w_pix[4:2], w_pix[4]} : 4'd0;
        r_vga_b  <= r_act_d ? {w_pix[1:0], w_pix[1:0]} : 4'd0;
      end
    end
  end

  assign vgactl_addr = r_addr;
  assign vga_r       = r_vga_r;
  assign vga_g       = r_vga_g;
  assign vga_b       = r_vga_b;
  assign vga_hs      = r_vga_hs;
  assign vga_vs      = r_vga_vs;

`ifdef VGA_VBLANK_IRQ_EN
  logic r_irq;

  always_ff @(posedge memclk) begin
    if (!rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_pix_tick && w_h_wrap && (r_vcnt == 10'(V_VIS - 1));
    end
  end

  assign vblank_irq = r_irq;
`else
  assign vblank_irq = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken raster; expected outputs come from a per-pixel-period
// model of position, framebuffer contents and a fixed two-period output lag.
module tb_vga_scanout;

  localparam int CLK_DIV   = 4;
  localparam int READ_LAT  = 2;
  localparam int H_VIS     = 16;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 4;
  localparam int H_BP      = 2;
  localparam int V_VIS     = 8;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 1;
  localparam int FB_W      = 8;
  localparam int HT        = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT        = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME     = HT * VT;
  localparam int FBN       = FB_W * (V_VIS / 2);
  localparam int LAST_ADDR = FBN - 1;

  logic        memclk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] vgactl_addr;
  logic [7:0]  vgactl_dat;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vblank_irq;

  always #5 memclk = ~memclk;

  vga_scanout #(
    .CLK_DIV (CLK_DIV),
    .READ_LAT(READ_LAT),
    .H_VIS   (H_VIS),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_VIS   (V_VIS),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .FB_W    (FB_W)
  ) dut (
    .memclk     (memclk),
    .rst        (rst),
    .vgactl_addr(vgactl_addr),
    .vgactl_dat (vgactl_dat),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vblank_irq (vblank_irq)
  );

  // Framebuffer and a two-register read pipeline; random data while in reset.
  logic [7:0] fb [FBN];
  logic [7:0] g_stage;
  always @(posedge memclk) begin
    if (!rst) begin
      g_stage    <= 8'($urandom);
      vgactl_dat <= 8'($urandom);
    end else begin
      g_stage    <= fb[int'(vgactl_addr) % FBN];
      vgactl_dat <= g_stage;
    end
  end

  // Sync pulse width / spacing recorder, in memclk cycles.
  logic rec_en = 1'b0;
  int   cyc = 0;
  logic prev_hs = 1'b1;
  logic prev_vs = 1'b1;
  int   hs_fall = -1;
  int   vs_fall = -1;
  int   hs_w[$];
  int   hs_gap[$];
  int   vs_w[$];
  int   vs_gap[$];
  always @(posedge memclk) begin
    if (rec_en) begin
      cyc     <= cyc + 1;
      prev_hs <= vga_hs;
      prev_vs <= vga_vs;
      if (prev_hs && !vga_hs) begin
        if (hs_fall >= 0) hs_gap.push_back(cyc - hs_fall);
        hs_fall <= cyc;
      end
      if (!prev_hs && vga_hs && hs_fall >= 0) hs_w.push_back(cyc - hs_fall);
      if (prev_vs && !vga_vs) begin
        if (vs_fall >= 0) vs_gap.push_back(cyc - vs_fall);
        vs_fall <= cyc;
      end
      if (!prev_vs && vga_vs && vs_fall >= 0) vs_w.push_back(cyc - vs_fall);
    end
  end

  int checks = 0;
  int errors = 0;
  int m = 0;
  int pat = 0;
  logic [16:0] exp_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int hpos(input int n);
    return (n % FRAME) % HT;
  endfunction

  function automatic int vpos(input int n);
    return (n % FRAME) / HT;
  endfunction

  function automatic logic act(input int n);
    return (hpos(n) < H_VIS) && (vpos(n) < V_VIS);
  endfunction

  function automatic int fb_index(input int n);
    return (vpos(n) / 2) * FB_W + hpos(n) / 2;
  endfunction

  function automatic logic hs_ref(input int n);
    return !((hpos(n) >= H_VIS + H_FP) && (hpos(n) < H_VIS + H_FP + H_SYNC));
  endfunction

  function automatic logic vs_ref(input int n);
    return !((vpos(n) >= V_VIS + V_FP) && (vpos(n) < V_VIS + V_FP + V_SYNC));
  endfunction

  // Scale 3- and 2-bit channels to 4 bits arithmetically.
  function automatic logic [11:0] expand(input logic [7:0] c);
    int r = int'(c[7:5]);
    int g = int'(c[4:2]);
    int b = int'(c[1:0]);
    return {4'(2 * r + int'(r >= 4)), 4'(2 * g + int'(g >= 4)), 4'(b * 5)};
  endfunction

  task automatic fill(input int p);
    for (int i = 0; i < FBN; i++) begin
      case (p % 4)
        0:       fb[i] = 8'($urandom);
        1:       fb[i] = 8'hE3;
        2:       fb[i] = 8'h1C;
        default: fb[i] = 8'hFF;
      endcase
    end
  endtask

  task automatic check_reset_state();
    chk("rst_rgb", {20'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_sync", {30'd0, vga_hs, vga_vs}, 32'd3);
    chk("rst_addr", {15'd0, vgactl_addr}, 32'd0);
    chk("rst_irq", {31'd0, vblank_irq}, 32'd0);
  endtask

  // Advances one pixel period; called with time at the negedge of the period's first cycle.
  task automatic run_period();
    logic [11:0] col;
    logic        hs_e;
    logic        vs_e;
    logic        irq_e;
    // Only swap contents deep in vertical blanking, when no read is in flight.
    if (hpos(m) == 0 && vpos(m) == V_VIS + 1) begin
      pat++;
      fill(pat);
    end
    if (m >= 1 && act(m - 1)) exp_addr = 17'(fb_index(m - 1));
    col  = (m >= 2 && act(m - 2)) ? expand(fb[fb_index(m - 2)]) : 12'd0;
    hs_e = (m >= 2) ? hs_ref(m - 2) : 1'b1;
    vs_e = (m >= 2) ? vs_ref(m - 2) : 1'b1;
`ifdef VGA_VBLANK_IRQ_EN
    irq_e = (hpos(m + 1) == 0) && (vpos(m + 1) == V_VIS);
`else
    irq_e = 1'b0;
`endif
    for (int c = 1; c <= 4; c++) begin
      @(negedge memclk);
      if (c == 1 || c == 3) begin
        chk("rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, col});
        chk("sync", {30'd0, vga_hs, vga_vs}, {30'd0, hs_e, vs_e});
        chk("addr", {15'd0, vgactl_addr}, {15'd0, exp_addr});
      end
      if (c == 1 && m >= 1 && hpos(m - 1) == H_VIS - 1 && vpos(m - 1) == V_VIS - 1)
        chk("last_addr", {15'd0, vgactl_addr}, LAST_ADDR);
      if (c == 1) chk("addr_bound", {31'd0, vgactl_addr <= 17'(LAST_ADDR)}, 32'd1);
      chk("irq", {31'd0, vblank_irq}, {31'd0, (c == 4) ? irq_e : 1'b0});
    end
    m++;
  endtask

  initial begin
    fill(0);
    rst = 1'b0;
    repeat (5) @(negedge memclk);
    check_reset_state();
    rec_en = 1'b1;
    rst    = 1'b1;
    m      = 0;
    repeat (3 * FRAME + 5 * HT) run_period();

    // One-cycle reset in the middle of a frame, then a full frame from scratch.
    rec_en = 1'b0;
    rst    = 1'b0;
    @(negedge memclk);
    check_reset_state();
    rst      = 1'b1;
    m        = 0;
    exp_addr = '0;
    repeat (FRAME + 2) run_period();

    chk("hs_pulses", {31'd0, hs_w.size() >= 3 * VT}, 32'd1);
    chk("vs_pulses", {31'd0, vs_w.size() >= 3}, 32'd1);
    foreach (hs_w[i]) chk("hs_width", hs_w[i], H_SYNC * CLK_DIV);
    foreach (hs_gap[i]) chk("hs_period", hs_gap[i], HT * CLK_DIV);
    foreach (vs_w[i]) chk("vs_width", vs_w[i], V_SYNC * HT * CLK_DIV);
    foreach (vs_gap[i]) chk("vs_period", vs_gap[i], FRAME * CLK_DIV);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
